nonrestoring_div_seq: RTL
=========================

Name: nonrestoring_div_seq

Overview:
Self-contained, parametrised sequential non-restoring divider. Divides a 2N-bit dividend by an N-bit divisor to give an N-bit quotient and an N-bit remainder. It is the generalised successor to the fixed 10/5-bit divider datapath: it folds the controller FSM, input checking and final remainder correction into one block, and uses a start/busy/done handshake. It sits as an arithmetic slave behind any controller that issues one division at a time.

Parameters:
N, 5, divisor/quotient/remainder width; dividend width is 2*N; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request; sampled only in IDLE
dividend  input  2N  dividend, captured on accepted start
divisor  input  N  divisor, captured on accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when q/r/flags are valid
q  output  N  quotient, held until next accepted start
r  output  N  remainder, held until next accepted start
ov  output  1  quotient overflow, valid with done, held
dbz  output  1  divide-by-zero, valid with done, held

Behaviour:
- Reset (rst=0, async): FSM goes to IDLE; busy=0, done=0, q=0, r=0, ov=0, dbz=0; internal registers are cleared. Reset mid-operation aborts the operation with no done.
- States: IDLE -> CHECK -> ITER (N cycles) -> FIX -> DONE -> IDLE.
- IDLE: if start=1, latch dividend into a (N+1)-bit partial remainder P plus an N-bit register Aq, latch divisor into D, and go to CHECK.
- CHECK (1 cycle):
  - dbz = (D==0).
  - ov = (dividend[2N-1:N] >= D) when D is not zero.
  - If either flag is set, go directly to DONE with q=0 and r=0.
  - Otherwise clear the iteration counter and go to ITER.
- ITER (one cycle per quotient bit, counter 0..N-1):
  - Shift {P,Aq} left by 1.
  - If P was non-negative before the shift, P = P - {0,D}; otherwise P = P + {0,D}.
  - The new quotient LSB = ~P[N] (the sign after the add/sub).
  - Adder width is N+1; no wider carry is kept.
  - Counter wraps to FIX after N iterations.
- FIX (1 cycle): if P is negative, P = P + {0,D} (restore). Then q = Aq and r = P[N-1:0].
- DONE: done=1 for exactly one cycle; busy=0 in the same cycle; go to IDLE.
- Latency: accepted start at edge k gives done at edge k+N+3 for a normal divide, and k+2 for the ov/dbz early exit.
- start while busy or in DONE is ignored; there is no queueing.
- start held high re-triggers on the first IDLE cycle after DONE. Back-to-back throughput is therefore N+4 cycles.
- Inputs may change freely after the start edge; only the latched copies are used.
- Results and flags hold their values until the next accepted start. They are then left stale (not cleared) until the new done.

Optional Feature:
- Macro: NONRESTORING_DIV_SIGNED_EN.
- Defined: adds input port signed_op (1 bit, sampled with start).
  - If signed_op=1, the operands are treated as two's complement.
  - CHECK replaces them with their magnitudes and records qsign = sign(dividend) XOR sign(divisor) and rsign = sign(dividend).
  - The ov test is applied to the magnitudes.
  - FIX negates q if qsign is set and r if rsign is set.
  - FIX additionally sets ov if the magnitude quotient exceeds 2^(N-1)-1 when positive, or 2^(N-1) when negative. In that case q=0 and r=0 are forced and the block still completes via DONE.
  - If signed_op=0, behaviour is identical to the unsigned case.
- Undefined: no signed_op port; unsigned only; FIX timing is unchanged.

Test Plan:
- N=5, dividend=100, divisor=7, start pulse -> done 8 cycles after start edge, q=14, r=2, ov=0, dbz=0.
- N=5, dividend=991, divisor=31 -> q=31, r=30, ov=0. Also dividend=1023, divisor=31 -> done after 2 cycles, ov=1, q=0, r=0.
- N=5, divisor=0, dividend=50 -> dbz=1, ov=0, done 2 cycles after start; then a valid start (100/7) clears dbz on its done.
- Start held high for 30 cycles with 100/7 -> done every 9 cycles; pulses of start during busy are ignored.
- Reset asserted during ITER cycle 3 -> busy, done, q, r, ov and dbz are 0 immediately (async) and no done follows; a post-reset start of 45/6 gives q=7, r=3.
- With NONRESTORING_DIV_SIGNED_EN and signed_op=1, N=5:
  - -100/7 -> q=-14, r=-2.
  - 100/-7 -> q=-14, r=2.
  - -512/1 -> ov=1.

Source files
------------

// File: rtl/nonrestoring_div_seq_if.sv
// Request/result bundle for nonrestoring_div_seq (N-bit divisor, 2N-bit dividend).
// NONRESTORING_DIV_SIGNED_EN adds the signed_op request bit.
interface nonrestoring_div_seq_if #(
  parameter int N = 5
);
  // Handshake: start is sampled only while the divider is idle; operands and
  // signed_op are captured on that edge and may change freely afterwards.
  // busy is high from the cycle after acceptance up to (not including) the
  // one-cycle done pulse; q/r/ov/dbz are valid with done and hold until the
  // next done. start during busy or done is dropped, never queued.
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
`ifdef NONRESTORING_DIV_SIGNED_EN
  logic           signed_op;
`endif
  logic           busy;
  logic           done;
  logic [N-1:0]   q;
  logic [N-1:0]   r;
  logic           ov;
  logic           dbz;

`ifdef NONRESTORING_DIV_SIGNED_EN
  modport master (
    output start, dividend, divisor, signed_op,
    input  busy, done, q, r, ov, dbz
  );
  modport slave (
    input  start, dividend, divisor, signed_op,
    output busy, done, q, r, ov, dbz
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, q, r, ov, dbz
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, q, r, ov, dbz
  );
`endif
endinterface

// File: rtl/nonrestoring_div_seq.sv
// Sequential non-restoring divider: 2N-bit dividend / N-bit divisor -> N-bit q, r.
// Optional two's-complement mode under macro NONRESTORING_DIV_SIGNED_EN.
module nonrestoring_div_seq #(
  parameter int N = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  nonrestoring_div_seq_if.slave dif,
  output logic [2:0]           state_dbg
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_n;

  logic [N:0]     p;
  logic [N-1:0]   aq;
  logic [N-1:0]   d;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   q_r, r_r;
  logic           ov_r, dbz_r;

  logic [2*N-1:0] dvd_raw, dvd_mag;
  logic [N-1:0]   dvs_mag;
  logic           chk_dbz, chk_ov;
  logic [N:0]     p_sh, p_new;
  logic [N-1:0]   aq_new;
  logic [N-1:0]   r_fix, q_res, r_res;
  logic           fix_ov;
  logic           busy_c, done_c;

`ifdef NONRESTORING_DIV_SIGNED_EN
  localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};
  logic sgn, qsign, rsign;
  logic dvd_neg, dvs_neg;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (dif.start) state_n = S_CHECK;
      S_CHECK: state_n = (chk_dbz || chk_ov) ? S_DONE : S_ITER;
      S_ITER:  if (cnt == CW'(N-1)) state_n = S_FIX;
      S_FIX:   state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_c    = 1'b0;
    done_c    = 1'b0;
    state_dbg = state;
    case (state)
      S_CHECK, S_ITER, S_FIX: busy_c = 1'b1;
      S_DONE:                 done_c = 1'b1;
      default: ;
    endcase
  end

  assign dif.busy = busy_c;
  assign dif.done = done_c;
  assign dif.q    = q_r;
  assign dif.r    = r_r;
  assign dif.ov   = ov_r;
  assign dif.dbz  = dbz_r;

  // Operand conditioning in CHECK: the latched dividend is {p[N-1:0], aq}.
  always_comb begin
    dvd_raw = {p[N-1:0], aq};
    dvd_mag = dvd_raw;
    dvs_mag = d;
`ifdef NONRESTORING_DIV_SIGNED_EN
    dvd_neg = sgn & dvd_raw[2*N-1];
    dvs_neg = sgn & d[N-1];
    if (dvd_neg) dvd_mag = -dvd_raw;
    if (dvs_neg) dvs_mag = -d;
`endif
    chk_dbz = (d == '0);
    // A high half >= divisor means the quotient cannot fit in N bits.
    chk_ov  = !chk_dbz && (dvd_mag[2*N-1:N] >= dvs_mag);
  end

  // One non-restoring step; the N+1-bit adder wraps, which is harmless
  // because the post-step remainder always lies in [-D, D).
  always_comb begin
    p_sh   = {p[N-1:0], aq[N-1]};
    p_new  = p[N] ? (p_sh + {1'b0, d}) : (p_sh - {1'b0, d});
    aq_new = {aq[N-2:0], ~p_new[N]};
  end

  // Final remainder restore and result formatting.
  always_comb begin
    r_fix  = p[N] ? (p[N-1:0] + d) : p[N-1:0];
    q_res  = aq;
    r_res  = r_fix;
    fix_ov = 1'b0;
`ifdef NONRESTORING_DIV_SIGNED_EN
    if (qsign) q_res = -aq;
    if (rsign) r_res = -r_fix;
    fix_ov = sgn && (qsign ? (aq > HALF) : (aq >= HALF));
    if (fix_ov) begin
      q_res = '0;
      r_res = '0;
    end
`endif
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p     <= '0;
      aq    <= '0;
      d     <= '0;
      cnt   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      ov_r  <= 1'b0;
      dbz_r <= 1'b0;
`ifdef NONRESTORING_DIV_SIGNED_EN
      sgn   <= 1'b0;
      qsign <= 1'b0;
      rsign <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (dif.start) begin
            p  <= {1'b0, dif.dividend[2*N-1:N]};
            aq <= dif.dividend[N-1:0];
            d  <= dif.divisor;
`ifdef NONRESTORING_DIV_SIGNED_EN
            sgn <= dif.signed_op;
`endif
          end
        end
        S_CHECK: begin
          p   <= {1'b0, dvd_mag[2*N-1:N]};
          aq  <= dvd_mag[N-1:0];
          d   <= dvs_mag;
          cnt <= '0;
`ifdef NONRESTORING_DIV_SIGNED_EN
          qsign <= dvd_neg ^ dvs_neg;
          rsign <= dvd_neg;
`endif
          if (chk_dbz || chk_ov) begin
            q_r   <= '0;
            r_r   <= '0;
            ov_r  <= chk_ov;
            dbz_r <= chk_dbz;
          end
        end
        S_ITER: begin
          p   <= p_new;
          aq  <= aq_new;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          p     <= {1'b0, r_fix};
          q_r   <= q_res;
          r_r   <= r_res;
          ov_r  <= fix_ov;
          dbz_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
